seg_p2s_shifter: RTL and testbench



---
 rtl/seg_p2s_pkg.sv | 16 +
 rtl/seg_p2s_tick.sv | 32 +++
 rtl/seg_p2s_shifter.sv | 123 ++++++++++++
 tb/tb_seg_p2s_shifter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/seg_p2s_pkg.sv
// Shared definitions for the segment-pattern serialiser: state encoding and
// default geometry of the display shift-register chain.
package seg_p2s_pkg;

  localparam int DATA_W_DEF      = 64;
  localparam int HALF_PERIOD_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SHIFT_LO = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_LATCH    = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

endpackage

// File: rtl/seg_p2s_tick.sv
// Half-period divider: o_tick marks the last clk cycle of a serial-clock phase.
// Cleared whenever the FSM changes state so every phase starts from zero.
module seg_p2s_tick #(
  parameter int HALF_PERIOD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_run,
  output logic o_tick
);

  localparam int CW = $clog2(HALF_PERIOD) + 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] r_div_cnt;
  logic          w_tick;

  assign w_tick = i_run && (r_div_cnt == LAST);
  assign o_tick = w_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
    end else if (i_clear || w_tick) begin
      r_div_cnt <= '0;
    end else if (i_run) begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_p2s_shifter.sv
// Serialises a parallel segment pattern MSB-first into a 74HC595-style chain,
// then strobes the storage latch so every digit updates together.
module seg_p2s_shifter
  import seg_p2s_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int HALF_PERIOD = HALF_PERIOD_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] par_data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              sdata,
  output logic              sload,
  output logic              sclr_n
);

  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] w_shreg_next;
  logic [BW-1:0]     r_bit_cnt;
  logic [BW-1:0]     w_bit_cnt_next;
  logic              w_tick;
  logic              w_run;
  logic              w_clear;

  logic r_busy, r_done, r_sclk, r_sdata, r_sload, r_sclr_n;
  logic w_busy_next, w_done_next, w_sclk_next, w_sdata_next, w_sload_next;

  assign w_run   = (r_state == ST_SHIFT_LO) || (r_state == ST_SHIFT_HI) ||
                   (r_state == ST_LATCH);
  assign w_clear = (w_state_next != r_state);

  seg_p2s_tick #(.HALF_PERIOD(HALF_PERIOD)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_clear),
    .i_run   (w_run),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (start)  w_state_next = ST_SHIFT_LO;
      ST_SHIFT_LO: if (w_tick) w_state_next = ST_SHIFT_HI;
      ST_SHIFT_HI: if (w_tick) w_state_next = (r_bit_cnt == '0) ? ST_LATCH : ST_SHIFT_LO;
      ST_LATCH:    if (w_tick) w_state_next = ST_DONE;
      ST_DONE:     w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  // The shift/count only advance on a data-carrying HI exit; the last bit falls into LATCH.
  always_comb begin
    w_shreg_next   = r_shreg;
    w_bit_cnt_next = r_bit_cnt;
    if (r_state == ST_IDLE && start) begin
      w_shreg_next   = par_data;
      w_bit_cnt_next = BIT_LAST;
    end else if (r_state == ST_SHIFT_HI && w_tick && r_bit_cnt != '0) begin
      w_shreg_next   = {r_shreg[DATA_W-2:0], 1'b0};
      w_bit_cnt_next = r_bit_cnt - 1'b1;
    end
  end

  // Outputs are decoded from the upcoming state so they register in step with it.
  always_comb begin
    w_busy_next  = (w_state_next != ST_IDLE);
    w_done_next  = (w_state_next == ST_DONE);
    w_sclk_next  = (w_state_next == ST_SHIFT_HI);
    w_sload_next = (w_state_next == ST_LATCH);
    w_sdata_next = r_sdata;
    if (w_state_next == ST_SHIFT_LO) begin
      w_sdata_next = w_shreg_next[DATA_W-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sclk    <= 1'b0;
      r_sdata   <= 1'b0;
      r_sload   <= 1'b0;
      r_sclr_n  <= 1'b0;
    end else begin
      r_shreg   <= w_shreg_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
      r_sclk    <= w_sclk_next;
      r_sdata   <= w_sdata_next;
      r_sload   <= w_sload_next;
      r_sclr_n  <= 1'b1;
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign sclk   = r_sclk;
  assign sdata  = r_sdata;
  assign sload  = r_sload;
  assign sclr_n = r_sclr_n;

endmodule

// File: tb/tb_seg_p2s_shifter.sv
// Directed bench for the segment serialiser: one instance at default timing,
// one at HALF_PERIOD=1 for the back-to-back case.
module tb_seg_p2s_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_start, b_start;
  logic [63:0] a_par, b_par;
  logic a_busy, a_done, a_sclk, a_sdata, a_sload, a_sclr_n;
  logic b_busy, b_done, b_sclk, b_sdata, b_sload, b_sclr_n;

  always #5 clk = ~clk;

  seg_p2s_shifter #(.DATA_W(64), .HALF_PERIOD(2)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .par_data(a_par),
    .busy(a_busy), .done(a_done), .sclk(a_sclk), .sdata(a_sdata),
    .sload(a_sload), .sclr_n(a_sclr_n)
  );

  seg_p2s_shifter #(.DATA_W(64), .HALF_PERIOD(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .par_data(b_par),
    .busy(b_busy), .done(b_done), .sclk(b_sclk), .sdata(b_sdata),
    .sload(b_sload), .sclr_n(b_sclr_n)
  );

  int errors = 0;
  int checks = 0;

  logic [63:0] cap;
  int rises, dones, done_cyc, busy_first, busy_last, busy_cnt;
  int sload_cnt, sload_first, sload_last, unstable, sclk_bad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one transfer and tallies what the pins did, cycle 1 = first cycle after acceptance.
  task automatic xfer(input bit sel, input bit pre, input logic [63:0] data, input int ncyc,
                      input int inj_cyc, input logic [63:0] inj_data,
                      input int abort_rise, input bit rearm);
    logic p_sclk, p_sdata, p_done;
    logic o_busy, o_done, o_sclk, o_sdata, o_sload;
    cap = '0; rises = 0; dones = 0; done_cyc = -1; busy_first = -1; busy_last = -1;
    busy_cnt = 0; sload_cnt = 0; sload_first = -1; sload_last = -1; unstable = 0; sclk_bad = 0;
    if (sel) b_par = data; else a_par = data;
    if (!pre) begin
      @(negedge clk);
      if (sel) b_start = 1'b1; else a_start = 1'b1;
    end
    @(negedge clk);
    a_start = 1'b0;
    b_start = 1'b0;
    p_sclk = 1'b0; p_sdata = 1'b0; p_done = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (c > 1) @(negedge clk);
      o_busy  = sel ? b_busy  : a_busy;
      o_done  = sel ? b_done  : a_done;
      o_sclk  = sel ? b_sclk  : a_sclk;
      o_sdata = sel ? b_sdata : a_sdata;
      o_sload = sel ? b_sload : a_sload;
      if (rearm && p_done) begin
        chk("idle_after_done", {63'd0, o_busy}, 64'd0);
        if (sel) b_start = 1'b1; else a_start = 1'b1;
        return;
      end
      if (o_busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (o_sload) begin
        sload_cnt++;
        if (sload_first < 0) sload_first = c;
        sload_last = c;
      end
      if (o_done) begin
        dones++;
        done_cyc = c;
      end
      if (o_sclk && !p_sclk) begin
        rises++;
        cap = {cap[62:0], o_sdata};
        if (c > 1 && o_sdata !== p_sdata) unstable++;
      end
      if (o_sclk && p_sclk && o_sdata !== p_sdata) unstable++;
      if (sel && c <= 128 && o_sclk !== ((c % 2) == 0)) sclk_bad++;
      if (c == inj_cyc) begin
        a_start = 1'b1;
        a_par   = inj_data;
      end
      if (c == inj_cyc + 1) a_start = 1'b0;
      if (abort_rise > 0 && rises == abort_rise) begin
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {58'd0, a_busy, a_done, a_sclk, a_sdata, a_sload, a_sclr_n}, 64'd0);
        return;
      end
      p_sclk = o_sclk; p_sdata = o_sdata; p_done = o_done;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_start = 1'b0; b_start = 1'b0;
    a_par = '0; b_par = '0;

    // Reset and release
    repeat (5) @(negedge clk);
    chk("reset_a", {58'd0, a_busy, a_done, a_sclk, a_sdata, a_sload, a_sclr_n}, 64'd0);
    chk("reset_b", {58'd0, b_busy, b_done, b_sclk, b_sdata, b_sload, b_sclr_n}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("sclr_n_a_release", {63'd0, a_sclr_n}, 64'd1);
    chk("sclr_n_b_release", {63'd0, b_sclr_n}, 64'd1);
    repeat (10) @(negedge clk);
    chk("idle_quiet", {59'd0, a_busy, a_done, a_sclk, a_sdata, a_sload}, 64'd0);
    $display("reset: done");

    // End bits set: framing and cycle timing
    xfer(1'b0, 1'b0, 64'h8000_0000_0000_0001, 270, -10, 64'd0, 0, 1'b0);
    chk("t1_stream", cap, 64'h8000_0000_0000_0001);
    chk("t1_rises", rises, 64);
    chk("t1_sload_first", sload_first, 257);
    chk("t1_sload_last", sload_last, 258);
    chk("t1_sload_cnt", sload_cnt, 2);
    chk("t1_done_cyc", done_cyc, 259);
    chk("t1_done_cnt", dones, 1);
    chk("t1_busy_first", busy_first, 1);
    chk("t1_busy_last", busy_last, 259);
    chk("t1_busy_cnt", busy_cnt, 259);
    $display("xfer 8000000000000001: cap=%h rises=%0d done@%0d", cap, rises, done_cyc);

    // Mixed pattern: reassembly and data stability around sclk rises
    xfer(1'b0, 1'b0, 64'hA5A5_0F0F_FFFF_0000, 270, -10, 64'd0, 0, 1'b0);
    chk("t2_stream", cap, 64'hA5A5_0F0F_FFFF_0000);
    chk("t2_rises", rises, 64);
    chk("t2_sdata_stable", unstable, 0);
    $display("xfer a5a50f0fffff0000: cap=%h unstable=%0d", cap, unstable);

    // Start while busy (with new par_data) is ignored
    xfer(1'b0, 1'b0, 64'h1234_5678_9ABC_DEF0, 270, 40, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);
    chk("t3_stream", cap, 64'h1234_5678_9ABC_DEF0);
    chk("t3_done_cnt", dones, 1);
    chk("t3_done_cyc", done_cyc, 259);
    chk("t3_busy_last", busy_last, 259);
    $display("xfer 123456789abcdef0 + ignored start: cap=%h dones=%0d", cap, dones);

    // Reset at the 30th sclk rise
    xfer(1'b0, 1'b0, 64'hDEAD_BEEF_0000_FFFF, 270, -10, 64'd0, 30, 1'b0);
    chk("t4_rises_at_abort", rises, 30);
    chk("t4_no_sload", sload_cnt, 0);
    repeat (2) @(negedge clk);
    chk("t4_held_reset", {58'd0, a_busy, a_done, a_sclk, a_sdata, a_sload, a_sclr_n}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(1'b0, 1'b0, 64'h0000_0000_0000_0001, 270, -10, 64'd0, 0, 1'b0);
    chk("t4_post_stream", cap, 64'h1);
    chk("t4_post_rises", rises, 64);
    chk("t4_post_done_cyc", done_cyc, 259);
    $display("abort then xfer 1: cap=%h rises=%0d", cap, rises);

    // HALF_PERIOD=1, back-to-back start in the first idle cycle
    xfer(1'b1, 1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 140, -10, 64'd0, 0, 1'b1);
    chk("t5a_done_cyc", done_cyc, 130);
    chk("t5a_stream", cap, 64'hF0F0_F0F0_F0F0_F0F0);
    xfer(1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 140, -10, 64'd0, 0, 1'b0);
    chk("t5b_stream", cap, 64'h0123_4567_89AB_CDEF);
    chk("t5b_rises", rises, 64);
    chk("t5b_done_cyc", done_cyc, 130);
    chk("t5b_done_cnt", dones, 1);
    chk("t5b_sload_first", sload_first, 129);
    chk("t5b_sload_cnt", sload_cnt, 1);
    chk("t5b_sclk_pattern", sclk_bad, 0);
    chk("t5b_busy_cnt", busy_cnt, 130);
    $display("hp1 back-to-back: cap=%h done@%0d sload@%0d", cap, done_cyc, sload_first);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
